// File: rtl/pin_input_filter.sv
// Input conditioning for the 6502 pins: two-flop synchronizers, control
// glitch filters, clk0 edge strobes, period measurement and clock-loss flag.

module pin_glitch_filter #(
  parameter int unsigned FILT_LEN = 3,
  parameter logic        RST_VAL  = 1'b0
) (
  input  logic eclk,
  input  logic ereset_n,
  input  logic pin_i,
  output logic filt_d_o,
  output logic filt_q_o
);

  localparam logic [3:0] LAST = 4'(FILT_LEN - 1);

  logic       s1_q;
  logic       s2_q;
  logic       f_q;
  logic       f_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // The counter only runs while s2 disagrees with the output.
  always_comb begin
    f_d   = f_q;
    cnt_d = '0;
    if (s2_q != f_q) begin
      if (cnt_q == LAST) begin
        f_d = s2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      s1_q  <= RST_VAL;
      s2_q  <= RST_VAL;
      f_q   <= RST_VAL;
      cnt_q <= '0;
    end else begin
      s1_q  <= pin_i;
      s2_q  <= s1_q;
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign filt_d_o = f_d;
  assign filt_q_o = f_q;

endmodule

module pin_input_filter #(
  parameter int unsigned FILT_LEN  = 3,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 eclk,
  input  logic                 ereset_n,
  input  logic [7:0]           db_pin,
  input  logic                 res_pin,
  input  logic                 so_pin,
  input  logic                 clk0_pin,
  input  logic                 rdy_pin,
  input  logic                 nmi_pin,
  input  logic                 irq_pin,
  output logic [7:0]           db_s,
  output logic                 res_f,
  output logic                 so_f,
  output logic                 clk0_f,
  output logic                 rdy_f,
  output logic                 nmi_f,
  output logic                 irq_f,
  output logic                 clk0_rise,
  output logic                 clk0_fall,
  output logic [TIMEOUT_W-1:0] clk0_period,
  output logic                 period_valid,
  output logic                 clk0_lost
);

  // Bit order {irq, nmi, rdy, clk0, so, res}; res and clk0 idle low.
  localparam logic [5:0] CTRL_RST = 6'b111010;
  localparam int unsigned CLK0 = 2;

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] CNT_ONE =
    {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [7:0] db_s1_q;
  logic [7:0] db_s2_q;

  logic [5:0] ctrl_pin;
  logic [5:0] ctrl_nxt;
  logic [5:0] ctrl_f;

  logic rise_d;
  logic rise_q;
  logic fall_d;
  logic fall_q;

  logic [TIMEOUT_W-1:0] cnt_d;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] period_d;
  logic [TIMEOUT_W-1:0] period_q;
  logic                 valid_d;
  logic                 valid_q;
  logic                 seen_d;
  logic                 seen_q;
  logic                 lost_d;
  logic                 lost_q;

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      db_s1_q <= '0;
      db_s2_q <= '0;
    end else begin
      db_s1_q <= db_pin;
      db_s2_q <= db_s1_q;
    end
  end

  assign ctrl_pin = {irq_pin, nmi_pin, rdy_pin,
                     clk0_pin, so_pin, res_pin};

  for (genvar i = 0; i < 6; i++) begin : g_filt
    pin_glitch_filter #(
      .FILT_LEN (FILT_LEN),
      .RST_VAL  (CTRL_RST[i])
    ) u_filt (
      .eclk     (eclk),
      .ereset_n (ereset_n),
      .pin_i    (ctrl_pin[i]),
      .filt_d_o (ctrl_nxt[i]),
      .filt_q_o (ctrl_f[i])
    );
  end

  // Strobes register on the same edge the filtered clk0 changes.
  always_comb begin
    rise_d = ctrl_nxt[CLK0] & ~ctrl_f[CLK0];
    fall_d = ~ctrl_nxt[CLK0] & ctrl_f[CLK0];
  end

  // A rise beats saturation in the same cycle.
  always_comb begin
    period_d = period_q;
    valid_d  = valid_q;
    seen_d   = seen_q;
    lost_d   = lost_q;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    if (rise_d) begin
      cnt_d  = CNT_ONE;
      seen_d = 1'b1;
      lost_d = 1'b0;
      if (seen_q) begin
        period_d = cnt_q;
        valid_d  = 1'b1;
      end
    end else if (cnt_q == CNT_MAX) begin
      lost_d  = 1'b1;
      valid_d = 1'b0;
      seen_d  = 1'b0;
    end
  end

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      seen_q   <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      lost_q   <= lost_d;
    end
  end

  assign db_s         = db_s2_q;
  assign res_f        = ctrl_f[0];
  assign so_f         = ctrl_f[1];
  assign clk0_f       = ctrl_f[2];
  assign rdy_f        = ctrl_f[3];
  assign nmi_f        = ctrl_f[4];
  assign irq_f        = ctrl_f[5];
  assign clk0_rise    = rise_q;
  assign clk0_fall    = fall_q;
  assign clk0_period  = period_q;
  assign period_valid = valid_q;
  assign clk0_lost    = lost_q;

endmodule
